// File: rtl/handle_fifo_ctrl.sv
// Pointer/flow-control engine turning a registered-read dual-port RAM into a
// streaming FIFO, with a two-entry output stage hiding the RAM read latency.
module handle_fifo_ctrl #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic                  pop_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH+1:0] usedw,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic                  inflight_q, inflight_d;
  logic                  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  logic                  ovf_q, ovf_d;

  logic [PW-1:0] ram_count;
  logic [2:0]    stage_occ, stage_after_pop;
  logic          push_fire, pop_fire, issue;

  assign ram_count  = wr_q - rd_q;
  assign push_ready = (ram_count != DEPTH);
  assign push_fire  = push_valid & push_ready & ~flush;
  assign pop_fire   = out_vld_q & pop_ready;

  // The in-flight read already owns a slot in the output stage.
  assign stage_occ       = 3'(out_vld_q) + 3'(skid_vld_q) + 3'(inflight_q);
  assign stage_after_pop = stage_occ - 3'(pop_fire);
  assign issue           = (ram_count != '0) && (stage_after_pop < 3'd2);

  assign ram_we         = push_fire;
  assign ram_write_addr = wr_q[ADDR_WIDTH-1:0];
  assign ram_data       = push_data;
  assign ram_read_addr  = rd_q[ADDR_WIDTH-1:0];
  assign pop_valid      = out_vld_q;
  assign pop_data       = out_q;
  assign overflow       = ovf_q;
  assign usedw          = {1'b0, ram_count} + {{(ADDR_WIDTH-1){1'b0}}, stage_occ};

  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    inflight_d = inflight_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    out_d      = out_q;
    skid_d     = skid_q;
    ovf_d      = ovf_q;
    if (flush) begin
      wr_d       = '0;
      rd_d       = '0;
      inflight_d = 1'b0;
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      wr_d       = wr_q + PW'(push_fire);
      rd_d       = rd_q + PW'(issue);
      inflight_d = issue;
      if (push_valid && !push_ready) ovf_d = 1'b1;
      // Oldest entry first: skid drains ahead of the arriving RAM word.
      if (pop_fire || !out_vld_q) begin
        if (skid_vld_q) begin
          out_d      = skid_q;
          out_vld_d  = 1'b1;
          skid_vld_d = inflight_q;
          if (inflight_q) skid_d = ram_q;
        end else if (inflight_q) begin
          out_d     = ram_q;
          out_vld_d = 1'b1;
        end else begin
          out_vld_d = 1'b0;
        end
      end else if (inflight_q) begin
        skid_d     = ram_q;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      inflight_q <= 1'b0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      inflight_q <= inflight_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_handle_fifo_ctrl.sv
// Randomized bench for handle_fifo_ctrl: a queue-based occupancy model plus a
// behavioural RAM, checked every cycle, with literal checks on key scenarios.
module tb_handle_fifo_ctrl;
  localparam int DW = 40;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, flush, push_valid, pop_ready;
  logic [DW-1:0] push_data, pop_data, ram_data, ram_q;
  logic          push_ready, pop_valid, ram_we, overflow;
  logic [AW-1:0] ram_write_addr, ram_read_addr;
  logic [AW+1:0] usedw;

  int nchk = 0;
  int nfail = 0;

  handle_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_data(ram_data),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q),
    .usedw(usedw), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM with registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  // Model: mq holds every handle in order; m_ready of them sit at the head in
  // the output stage, m_fly is the read in flight, the rest are in the RAM.
  logic [DW-1:0] mq[$];
  int m_ready = 0, m_fly = 0, m_wr = 0, m_rd = 0;
  bit m_ovf = 0;
  bit e_pr, e_pushf, e_popf, e_iss;

  function automatic int m_ram();
    return mq.size() - m_ready - m_fly;
  endfunction

  task automatic m_clear(input bit clr_ovf);
    mq.delete();
    m_ready = 0; m_fly = 0; m_wr = 0; m_rd = 0;
    if (clr_ovf) m_ovf = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_clear(1);
      else if (flush) m_clear(1);
      else begin
        e_pr    = m_ram() != DEPTH;
        e_pushf = push_valid && e_pr;
        e_popf  = (m_ready > 0) && pop_ready;
        e_iss   = (m_ram() > 0) && ((m_ready + m_fly - int'(e_popf)) < 2);
        if (push_valid && !e_pr) m_ovf = 1;
        if (e_popf) void'(mq.pop_front());
        if (e_pushf) begin mq.push_back(push_data); m_wr++; end
        if (e_iss) m_rd++;
        m_ready = m_ready - int'(e_popf) + m_fly;
        m_fly   = int'(e_iss);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  bit c_pr;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      c_pr = m_ram() != DEPTH;
      chk("push_ready", 64'(push_ready), 64'(c_pr));
      chk("ram_we", 64'(ram_we), 64'(push_valid && c_pr && !flush));
      chk("ram_data", 64'(ram_data), 64'(push_data));
      chk("pop_valid", 64'(pop_valid), 64'(m_ready > 0));
      if (m_ready > 0) chk("pop_data", 64'(pop_data), 64'(mq[0]));
      chk("usedw", 64'(usedw), 64'(mq.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("ram_write_addr", 64'(ram_write_addr), 64'(m_wr % DEPTH));
      chk("ram_read_addr", 64'(ram_read_addr), 64'(m_rd % DEPTH));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rnd_traffic(input int n, input bit guard);
    for (int i = 0; i < n; i++) begin
      pop_ready  = 1'($urandom % 2);
      push_valid = guard ? (push_ready && ($urandom % 4 != 0)) : 1'($urandom % 2);
      push_data  = {8'($urandom), 32'($urandom)};
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    cyc(2);
    reset = 1'b0;
    #2;
    chk("rst_usedw", 64'(usedw), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_pop_data", 64'(pop_data), 64'd0);

    // Single handle latency.
    push_valid = 1'b1; push_data = 40'hA5_0000_0001; pop_ready = 1'b1;
    @(negedge clk); push_valid = 1'b0; #2;
    chk("lat_e0_usedw", 64'(usedw), 64'd1);
    chk("lat_e0_pv", 64'(pop_valid), 64'd0);
    @(negedge clk); #2;
    chk("lat_e1_usedw", 64'(usedw), 64'd1);
    chk("lat_e1_pv", 64'(pop_valid), 64'd0);
    @(negedge clk); #2;
    chk("lat_e2_pv", 64'(pop_valid), 64'd1);
    chk("lat_e2_data", 64'(pop_data), 64'hA5_0000_0001);
    chk("lat_e2_usedw", 64'(usedw), 64'd1);
    @(negedge clk); #2;
    chk("lat_e3_usedw", 64'(usedw), 64'd0);
    chk("lat_e3_pv", 64'(pop_valid), 64'd0);

    // 40 sequential handles through the wrap.
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      push_valid = 1'b1; push_data = 40'(i); pop_ready = 1'b1;
      @(negedge clk);
    end
    push_valid = 1'b0;
    cyc(6);
    chk("stream_drained", 64'(usedw), 64'd0);

    // Fill to capacity with the consumer stalled.
    pop_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      push_valid = 1'b1; push_data = 40'(1000 + i);
      @(negedge clk);
    end
    push_valid = 1'b0; #2;
    chk("full_usedw", 64'(usedw), 64'd18);
    chk("full_push_ready", 64'(push_ready), 64'd0);
    chk("full_ovf_clear", 64'(overflow), 64'd0);
    chk("full_head", 64'(pop_data), 64'd1000);
    @(negedge clk);
    push_valid = 1'b1; push_data = 40'h77;
    @(negedge clk);
    push_valid = 1'b0; #2;
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_usedw", 64'(usedw), 64'd18);

    // Random pop_ready while full, pushing whenever there is room.
    @(negedge clk);
    rnd_traffic(300, 1'b1);
    push_valid = 1'b0; pop_ready = 1'b1;
    cyc(30);
    chk("drain_usedw", 64'(usedw), 64'd0);

    // Flush with a simultaneous push.
    pop_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_valid = 1'b1; push_data = 40'(2000 + i);
      @(negedge clk);
    end
    flush = 1'b1; push_valid = 1'b1; push_data = 40'hDEAD;
    @(negedge clk);
    flush = 1'b0; push_valid = 1'b0; #2;
    chk("flush_usedw", 64'(usedw), 64'd0);
    chk("flush_pv", 64'(pop_valid), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_data = 40'(3000 + i);
      @(negedge clk);
    end
    push_valid = 1'b0;
    cyc(10);
    chk("post_flush_drained", 64'(usedw), 64'd0);

    // Asynchronous reset between edges.
    rnd_traffic(40, 1'b0);
    rnd_traffic(5, 1'b1);
    push_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("arst_pv", 64'(pop_valid), 64'd0);
    chk("arst_usedw", 64'(usedw), 64'd0);
    chk("arst_push_ready", 64'(push_ready), 64'd1);
    chk("arst_pop_data", 64'(pop_data), 64'd0);
    chk("arst_rd_addr", 64'(ram_read_addr), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    rnd_traffic(200, 1'b1);
    push_valid = 1'b0; pop_ready = 1'b1;
    cyc(30);
    chk("final_usedw", 64'(usedw), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
